// File: rtl/vector_pkg.sv
// Shared vector types and constants for the ray-marcher vec3 datapath.
// Also holds the normaliser state type and iteration counts.
package vector_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int FRACT           = 16;
    localparam int NORM_SQRT_ITERS = DATA_WIDTH;
    localparam int NORM_DIV_ITERS  = DATA_WIDTH + FRACT;

    typedef logic signed [DATA_WIDTH-1:0] num_t;

    typedef struct packed {
        num_t x;
        num_t y;
        num_t z;
    } vec3_t;

    typedef enum logic [2:0] {IDLE, DOT, SQRT, DIV, DONE} norm_state_t;

    // Unsigned magnitude; the most negative value maps to 2^(DATA_WIDTH-1).
    function automatic logic [DATA_WIDTH-1:0] mag(input num_t v);
        return v[DATA_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Bit-serial unsigned restoring divider, one quotient bit per cycle, MSB first.
// The start cycle already produces the first quotient bit, so a divide takes DVD_W edges.
module seq_udiv
    import vector_pkg::*;
#(
    parameter int DVD_W = DATA_WIDTH + FRACT,
    parameter int DIV_W = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] divisor_r;
    logic [DIV_W-1:0] cur_rem;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] next_rem;
    logic [DVD_W-1:0] dvd_sh;
    logic [DVD_W-1:0] cur_dvd;
    logic [DVD_W-1:0] cur_q;
    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   diff;
    logic             take;
    logic [CNT_W-1:0] count;

    // A start overrides the stored operands so the first step uses the new ones directly.
    always_comb begin
        cur_rem  = start ? '0       : rem;
        cur_div  = start ? divisor  : divisor_r;
        cur_dvd  = start ? dividend : dvd_sh;
        cur_q    = start ? '0       : quotient;
        trial    = {cur_rem, cur_dvd[DVD_W-1]};
        diff     = trial - {1'b0, cur_div};
        take     = (trial >= {1'b0, cur_div});
        next_rem = DIV_W'(take ? diff : trial);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            divisor_r <= '0;
            dvd_sh    <= '0;
            quotient  <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rem       <= next_rem;
                divisor_r <= cur_div;
                dvd_sh    <= cur_dvd << 1;
                quotient  <= {cur_q[DVD_W-2:0], take};
            end
            if (start) begin
                count <= CNT_W'(DVD_W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                count <= count - 1'b1;
                if (count == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vec3_normalize.sv
// Sequential vec3 normaliser: squared length, bit-serial square root, then three
// bit-serial divides giving v/|v| in Q16.16 alongside the saturated length.
module vec3_normalize
    import vector_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  vec3_t                 in_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output vec3_t                 out_vec,
    output logic [DATA_WIDTH-1:0] out_len,
    output logic                  out_zero
);

    localparam int SQ_CNT_W = $clog2(NORM_SQRT_ITERS);

    norm_state_t                 state;
    vec3_t                       vec_r;
    logic [2*DATA_WIDTH-1:0]     sq_src;
    logic [DATA_WIDTH+1:0]       sq_rem;
    logic [DATA_WIDTH-1:0]       root;
    logic [SQ_CNT_W-1:0]         sq_cnt;
    logic [1:0]                  comp_idx;

    logic [2*DATA_WIDTH-1:0]     dot_sum;
    logic [DATA_WIDTH+3:0]       sq_shifted;
    logic [DATA_WIDTH+3:0]       sq_trial;
    logic                        sq_take;
    logic [DATA_WIDTH-1:0]       root_next;
    logic                        sq_last;

    logic                        div_start;
    logic                        div_busy;
    logic                        div_done;
    logic [NORM_DIV_ITERS-1:0]   div_dividend;
    logic [DATA_WIDTH-1:0]       div_divisor;
    logic [NORM_DIV_ITERS-1:0]   div_quot;
    num_t                        next_comp;
    num_t                        done_comp;
    num_t                        q_val;
    num_t                        q_signed;

    always_comb begin
        dot_sum = 64'(mag(vec_r.x)) * 64'(mag(vec_r.x))
                + 64'(mag(vec_r.y)) * 64'(mag(vec_r.y))
                + 64'(mag(vec_r.z)) * 64'(mag(vec_r.z));

        sq_shifted = {sq_rem, sq_src[2*DATA_WIDTH-1 -: 2]};
        sq_trial   = {2'b00, root, 2'b01};
        sq_take    = (sq_shifted >= sq_trial);
        root_next  = {root[DATA_WIDTH-2:0], sq_take};
        sq_last    = (state == SQRT) && (sq_cnt == SQ_CNT_W'(NORM_SQRT_ITERS - 1));

        // x starts on the last root step using the root's final value, y and z chain off done.
        next_comp = vec_r.x;
        done_comp = vec_r.x;
        case (comp_idx)
            2'd0:    begin next_comp = vec_r.y; done_comp = vec_r.x; end
            2'd1:    begin next_comp = vec_r.z; done_comp = vec_r.y; end
            default: begin next_comp = vec_r.z; done_comp = vec_r.z; end
        endcase
        if (state != DIV) begin
            next_comp = vec_r.x;
        end

        div_start    = sq_last ||
                       ((state == DIV) && div_done && !div_busy && (comp_idx != 2'd2));
        div_dividend = {mag(next_comp), FRACT'(0)};
        div_divisor  = (state == SQRT) ? root_next : root;

        q_val    = num_t'(div_quot);
        q_signed = done_comp[DATA_WIDTH-1] ? -q_val : q_val;
    end

    seq_udiv #(
        .DVD_W (NORM_DIV_ITERS),
        .DIV_W (DATA_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec_r     <= '0;
            sq_src    <= '0;
            sq_rem    <= '0;
            root      <= '0;
            sq_cnt    <= '0;
            comp_idx  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_len   <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec_r    <= in_vec;
                        in_ready <= 1'b0;
                        state    <= DOT;
                    end
                end
                DOT: begin
                    sq_src <= dot_sum;
                    sq_rem <= '0;
                    root   <= '0;
                    sq_cnt <= '0;
                    if (dot_sum == '0) begin
                        out_vec   <= '0;
                        out_len   <= '0;
                        out_zero  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SQRT;
                    end
                end
                SQRT: begin
                    sq_src <= sq_src << 2;
                    sq_rem <= (DATA_WIDTH+2)'(sq_take ? sq_shifted - sq_trial : sq_shifted);
                    root   <= root_next;
                    sq_cnt <= sq_cnt + 1'b1;
                    if (sq_last) begin
                        comp_idx <= 2'd0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        case (comp_idx)
                            2'd0:    out_vec.x <= q_signed;
                            2'd1:    out_vec.y <= q_signed;
                            default: out_vec.z <= q_signed;
                        endcase
                        if (comp_idx == 2'd2) begin
                            out_len   <= root[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : root;
                            out_zero  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            comp_idx <= comp_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vec3_normalize.md
# vec3_normalize

Sequential unit-vector stage for the ray marcher. It accepts one signed fixed-point vec3 (for example a ray direction or an SDF gradient), then computes its Euclidean length and the normalised vector v/|v|. It sits directly downstream of the vec3 arithmetic (vec3_sub/vec3_dot results) and feeds the march loop. It uses a bit-serial square root and a bit-serial divider instead of wide combinational dividers.

## Interface
- DATA_WIDTH, 32, element width (matches the shared package)
- FRACT, 16, fractional bits (Q16.16)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  high only in IDLE
- in_vec  in  vec3  signed Q16.16 vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_vec  out  vec3  normalised vector, Q16.16, each component in [-1.0, 1.0]
- out_len  out  DATA_WIDTH  |v| in Q16.16, saturated to 0x7FFF_FFFF
- out_zero  out  1  input was the zero vector

## Operation
- States: IDLE, DOT, SQRT, DIV, DONE.
- IDLE: in_ready=1. When in_valid is high, latch in_vec and go to DOT.
- DOT (1 cycle): S = x²+y²+z², as an unsigned 2*DATA_WIDTH sum of full-precision products with no shift. The maximum 3·2^62 fits in 64 bits. If S==0, go to DONE with out_zero=1, out_vec=0 and out_len=0. Otherwise go to SQRT.
- SQRT (DATA_WIDTH cycles): restoring integer square root, one result bit per cycle, MSB first. L = floor(√S) is |v| in Q16.16, unsigned, DATA_WIDTH bits.
- DIV (3 × (DATA_WIDTH+FRACT) cycles): components processed x, then y, then z.
  - q = floor((|c| << FRACT) / L), restoring division, one quotient bit per cycle.
  - |c| is taken as unsigned DATA_WIDTH, so -2^31 gives the magnitude 2^31.
  - L ≥ |c| always holds, so q ≤ 1<<FRACT.
  - The result is negated if c<0. Rounding truncates toward zero.
- DONE: out_valid=1. out_vec, out_len and out_zero are stable until the handshake (out_valid && out_ready). On the handshake, go to IDLE on the same edge.
- out_len = L if L[DATA_WIDTH-1]==0, otherwise 0x7FFF_FFFF.
- There is no overlap between vectors. in_ready is 0 in every state except IDLE, so inputs offered while busy are ignored.
- Reset, including mid-operation, does all of the following:
  - state returns to IDLE
  - out_valid=0, in_ready=1 after release
  - out_vec=0, out_len=0, out_zero=0
  - internal accumulators are cleared

## Timing
- The accept edge is edge 0.
- Non-zero vector: out_valid rises after edge 1 + DATA_WIDTH + 3·(DATA_WIDTH+FRACT). At the defaults this is edge 177.
- Zero vector: out_valid rises after edge 1.
- Back-to-back throughput: one vector per latency+1 cycles, because IDLE always costs one cycle.
- out_ready may be held high before DONE is reached. The handshake then completes on the first DONE cycle.
- All outputs are registered. There are no combinational in→out paths.

## Structure
- vector_pkg (shared) holds:
  - the vec3 and num types (already present)
  - new constants NORM_SQRT_ITERS = DATA_WIDTH and NORM_DIV_ITERS = DATA_WIDTH+FRACT
  - a typedef for the state enum norm_state_t
- Sub-module seq_udiv: unsigned restoring divider (start, dividend[DATA_WIDTH+FRACT], divisor[DATA_WIDTH], busy, done, quotient). It is instantiated once and reused for the three components. It is also reusable by other marcher stages.
- The square root stays inline in vec3_normalize.

## Test plan
- (3.0, 4.0, 0) = (0x0003_0000, 0x0004_0000, 0), with out_ready=1 → out_len 0x0005_0000, out_vec (0x0000_9999, 0x0000_CCCC, 0), out_zero 0, out_valid exactly 177 edges after accept.
- (0, -2.0, 0) → out_vec (0, 0xFFFF_0000, 0), out_len 0x0002_0000 (exact -1.0 boundary).
- (0, 0, 0) → out_zero 1, out_vec 0, out_len 0, out_valid 1 edge after accept.
- All components 0x8000_0000 → out_len 0x7FFF_FFFF (saturated), each component 0xFFFF_6C33 (-37837).
- (1.0, 0, 0) with out_ready held low 10 cycles in DONE → outputs stable and in_ready 0 throughout. A second in_valid offered meanwhile is not accepted. After the handshake, the next vector is accepted in IDLE.
- rst_n asserted mid-SQRT → out_valid 0 and in_ready 1 immediately after release. A following (3.0, 4.0, 0) gives the first scenario's result and latency.
